// File: rtl/clk_div_pkg.sv
// Shared constants, mode encoding and sizing helper for the programmable clock divider.
package clk_div_pkg;

  // 100 MHz / 480 Hz / 2: half-period count for a 480 Hz square wave.
  localparam int unsigned DEF_DIV_DEFAULT = 104167;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and registered outputs.
// A new divisor waits in pdiv until a terminal count (or an idle channel) so that
// the output never produces a truncated period.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             tog_q, tog_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  logic pulse;
  logic run;
  logic tc;
  logic apply_pend;
  logic apply_wr;

  assign pulse = (mode_e'(mode) == MODE_PULSE);

  // Terminal-count and divisor-update decisions for this cycle.
  always_comb begin
    run        = en && (div_q != '0);
    tc         = run && (cnt_q == div_q - CNT_W'(1));
    // An idle channel has no period to protect, so a pending value lands at once.
    apply_pend = pend_q && (tc || !run);
    // A write coinciding with the terminal count starts its period immediately.
    apply_wr   = wr && tc;
  end

  // Next-state for counter, divisor bookkeeping and the output flops.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    tog_d  = tog_q;
    tick_d = tc;

    if (pulse) begin
      tog_d = 1'b0;
    end else if (tc) begin
      tog_d = ~tog_q;
    end
    out_d = pulse ? tc : tog_d;

    if (apply_pend) begin
      div_d  = pdiv_q;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (apply_wr) begin
      div_d = wr_div;
      cnt_d = '0;
    end else begin
      if (wr) begin
        pdiv_d = wr_div;
        pend_d = 1'b1;
      end
      if (tc) begin
        cnt_d = '0;
      end else if (run) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEF_DIV);
      pdiv_q <= '0;
      pend_q <= 1'b0;
      tog_q  <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tog_q  <= tog_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: configuration decode plus NCH channels.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [NCH-1:0]           en,
  input  logic [NCH-1:0]           mode,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_width(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]         cfg_div,
  output logic [NCH-1:0]           clk_out,
  output logic [NCH-1:0]           tick
);

  localparam int unsigned CH_W = ch_width(NCH);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;

  // Ready mux and per-channel write strobes; out-of-range targets are always
  // ready and simply produce no strobe.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cfg_ch == CH_W'(k)) begin
        cfg_ready = ~pend[k];
      end
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      wr[k] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(k));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_in (clk_in),
      .reset  (reset),
      .en     (en[k]),
      .mode   (mode[k]),
      .wr     (wr[k]),
      .wr_div (cfg_div),
      .clk_out(clk_out[k]),
      .tick   (tick[k]),
      .pend   (pend[k])
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: directed scenarios plus random traffic,
// all checked against a per-channel behavioural model.
module tb_prog_clk_div;

  localparam int unsigned NCH     = 5;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEF_DIV = 12;
  localparam int unsigned CH_W    = 3;

  logic             clk_in = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   mode;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  always #5 clk_in = ~clk_in;

  prog_clk_div #(
    .NCH    (NCH),
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state per channel.
  int m_cnt [NCH];
  int m_div [NCH];
  int m_pdiv[NCH];
  bit m_pend[NCH];
  bit m_tog [NCH];
  bit m_out [NCH];
  bit m_tick[NCH];
  bit model_ok = 1'b0;
  bit last_acc = 1'b0;

  function automatic bit model_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit acc;
    acc = cfg_valid && model_ready();
    last_acc = acc;
    for (int k = 0; k < NCH; k++) begin
      bit wrk, active, tc;
      if (reset) begin
        m_cnt[k] = 0; m_div[k] = DEF_DIV; m_pdiv[k] = 0; m_pend[k] = 0;
        m_tog[k] = 0; m_out[k] = 0; m_tick[k] = 0;
        continue;
      end
      wrk    = acc && (int'(cfg_ch) == k);
      active = en[k] && (m_div[k] != 0);
      tc     = active && (m_cnt[k] + 1 == m_div[k]);
      m_tick[k] = tc;
      if (mode[k]) begin
        m_tog[k] = 0;
        m_out[k] = tc;
      end else begin
        if (tc) m_tog[k] = !m_tog[k];
        m_out[k] = m_tog[k];
      end
      if (m_pend[k] && (tc || !active)) begin
        m_div[k] = m_pdiv[k]; m_cnt[k] = 0; m_pend[k] = 0;
      end else if (wrk && tc) begin
        m_div[k] = int'(cfg_div); m_cnt[k] = 0;
      end else begin
        if (wrk) begin
          m_pdiv[k] = int'(cfg_div); m_pend[k] = 1;
        end
        if (active) m_cnt[k] = (m_cnt[k] + 1) % m_div[k];
      end
    end
    if (reset) model_ok = 1'b1;
  endtask

  // One clock: check ready, step model, wait edge, check outputs.
  task automatic step();
    logic [NCH-1:0] exp_out, exp_tick;
    #1;
    if (model_ok) begin
      total++;
      if (cfg_ready !== model_ready()) begin
        bad++;
        $display("FAIL cfg_ready ch=%0d got=%b want=%b t=%0t", cfg_ch, cfg_ready,
                 model_ready(), $time);
      end
    end
    model_edge();
    @(posedge clk_in);
    #1;
    for (int k = 0; k < NCH; k++) begin
      exp_out[k]  = m_out[k];
      exp_tick[k] = m_tick[k];
    end
    total++;
    if (clk_out !== exp_out) begin
      bad++;
      $display("FAIL clk_out got=%b want=%b t=%0t", clk_out, exp_out, $time);
    end
    total++;
    if (tick !== exp_tick) begin
      bad++;
      $display("FAIL tick got=%b want=%b t=%0t", tick, exp_tick, $time);
    end
  endtask

  task automatic write_cfg(input int ch, input int d);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(d);
    do begin
      step();
      n++;
    end while (!last_acc && n < 100);
    cfg_valid = 1'b0;
    total++;
    if (!last_acc) begin
      bad++;
      $display("FAIL cfg_accept ch=%0d got=timeout want=accepted", ch);
    end
  endtask

  task automatic wait_applied(input int ch, input int d);
    int n = 0;
    while ((m_div[ch] != d || m_pend[ch]) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL apply_timeout ch=%0d got=div%0d want=div%0d", ch, m_div[ch], d);
    end
  endtask

  task automatic wait_cnt(input int ch, input int c);
    int n = 0;
    while (m_cnt[ch] != c && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run_until_tick(input int ch, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick[ch] !== 1'b1 && n < bound);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; en = '1; mode = '0;
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd5;
    step();
    en = NCH'($urandom); mode = NCH'($urandom);
    step();
    cfg_valid = 1'b0;
    total++;
    if (clk_out !== '0 || tick !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%b want=0/0", clk_out, tick);
    end
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", cfg_ready);
    end
    reset = 1'b0; en = '1; mode = '0;
    run_until_tick(0, 3 * DEF_DIV, n);
    total++;
    if (n != DEF_DIV) begin
      bad++;
      $display("FAIL first_tick got=%0d want=%0d", n, DEF_DIV);
    end
    total++;
    if (clk_out[0] !== 1'b1) begin
      bad++;
      $display("FAIL first_rise got=%b want=1", clk_out[0]);
    end
    n = 0;
    do begin step(); n++; end while (clk_out[0] !== 1'b0 && n < 100);
    do begin step(); n++; end while (clk_out[0] !== 1'b1 && n < 100);
    total++;
    if (n != 2 * DEF_DIV) begin
      bad++;
      $display("FAIL toggle_period got=%0d want=%0d", n, 2 * DEF_DIV);
    end
  endtask

  task automatic test_write_mid_period();
    int n;
    write_cfg(1, 10);
    wait_applied(1, 10);
    wait_cnt(1, 4);
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd3;
    step();
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_ready_low got=%b want=0", cfg_ready);
    end
    n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL mid_pending_cycles got=%0d want=5", n);
    end
    total++;
    if (tick[1] !== 1'b1) begin
      bad++;
      $display("FAIL mid_apply_tick got=%b want=1", tick[1]);
    end
    for (int i = 0; i < 3; i++) begin
      run_until_tick(1, 20, n);
      total++;
      if (n != 3) begin
        bad++;
        $display("FAIL mid_new_period got=%0d want=3", n);
      end
    end
  endtask

  task automatic test_pulse();
    mode[2] = 1'b1;
    write_cfg(2, 1);
    wait_applied(2, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (clk_out[2] !== 1'b1 || tick[2] !== 1'b1) begin
        bad++;
        $display("FAIL pulse_div1 got=%b/%b want=1/1", clk_out[2], tick[2]);
      end
    end
    mode[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (clk_out[2] !== ((i % 2) == 0)) begin
        bad++;
        $display("FAIL toggle_div1 i=%0d got=%b want=%b", i, clk_out[2], (i % 2) == 0);
      end
    end
  endtask

  task automatic test_enable_hold();
    int  n;
    logic held;
    write_cfg(0, 5);
    wait_applied(0, 5);
    wait_cnt(0, 2);
    held  = clk_out[0];
    en[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (tick[0] !== 1'b0 || clk_out[0] !== held) begin
        bad++;
        $display("FAIL en_hold got=%b/%b want=0/%b", tick[0], clk_out[0], held);
      end
    end
    en[0] = 1'b1;
    run_until_tick(0, 20, n);
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL en_resume got=%0d want=3", n);
    end
  endtask

  task automatic test_halt();
    int  n;
    logic held;
    write_cfg(3, 0);
    wait_applied(3, 0);
    held = clk_out[3];
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (tick[3] !== 1'b0 || clk_out[3] !== held) begin
        bad++;
        $display("FAIL halt_hold got=%b/%b want=0/%b", tick[3], clk_out[3], held);
      end
    end
    write_cfg(3, 4);
    step();
    total++;
    if (m_div[3] != 4) begin
      bad++;
      $display("FAIL halt_apply got=%0d want=4", m_div[3]);
    end
    run_until_tick(3, 20, n);
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL halt_restart got=%0d want=4", n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      en        = NCH'(~($urandom & $urandom & $urandom));
      if ($urandom_range(0, 19) == 0) mode = NCH'($urandom);
      cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_ch    = CH_W'($urandom_range(0, 7));
      cfg_div   = CNT_W'($urandom_range(0, 6));
      step();
    end
    reset = 1'b0; cfg_valid = 1'b0; en = '1; mode = '0;
  endtask

  task automatic test_reset_pending();
    int n;
    write_cfg(1, 30);
    wait_applied(1, 30);
    wait_cnt(1, 5);
    write_cfg(1, 7);
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rp_pending got=%b want=0", cfg_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b1 || clk_out !== '0 || tick !== '0) begin
      bad++;
      $display("FAIL rp_cleared got=%b/%b/%b want=1/0/0", cfg_ready, clk_out, tick);
    end
    cfg_valid = 1'b1; cfg_ch = CH_W'(NCH); cfg_div = 16'd2;
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL rp_oob_ready got=%b want=1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0; cfg_ch = 3'd1;
    run_until_tick(1, 40, n);
    total++;
    if (n != DEF_DIV - 1 || tick !== '1) begin
      bad++;
      $display("FAIL rp_default_div got=%0d/%b want=%0d/%b", n, tick, DEF_DIV - 1, {NCH{1'b1}});
    end
  endtask

  initial begin
    reset = 1'b1; en = '0; mode = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    test_reset();
    test_write_mid_period();
    test_pulse();
    test_enable_hold();
    test_halt();
    test_random();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
